// File: rtl/xm_mem_arbiter.sv
// Two-port arbiter for the unified single-port memory: CPU port C and DMA/debug port D.
// Single-pulse requests are latched per port and served one at a time under a per-access watchdog.
module xm_mem_arbiter #(
  parameter int unsigned WORD       = 16,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            cEn_i,
  input  logic            cRW_i,
  input  logic            cByte_i,
  input  logic [WORD-1:0] cAddr_i,
  input  logic [WORD-1:0] cWData_i,
  output logic            cBusy_o,
  output logic            cWr_o,
  output logic            cErr_o,
  output logic [WORD-1:0] cRData_o,
  input  logic            dEn_i,
  input  logic            dRW_i,
  input  logic            dByte_i,
  input  logic [WORD-1:0] dAddr_i,
  input  logic [WORD-1:0] dWData_i,
  output logic            dBusy_o,
  output logic            dWr_o,
  output logic            dErr_o,
  output logic [WORD-1:0] dRData_o,
  output logic [1:0]      ovf_o,
  output logic            memEn_o,
  output logic            memRW_o,
  output logic            memByte_o,
  output logic [WORD-1:0] memAddr_o,
  output logic [WORD-1:0] memWData_o,
  input  logic [WORD-1:0] memRData_i,
  input  logic            memReady_i
);

  localparam int unsigned WdW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e          state_q;
  logic            pend_c_q, pend_d_q;
  logic            grant_q;  // 0 = C, 1 = D
  logic            last_q;
  logic            err_q;
  logic            rw_c_q, byte_c_q, rw_d_q, byte_d_q;
  logic [WORD-1:0] addr_c_q, wdata_c_q, rdata_c_q;
  logic [WORD-1:0] addr_d_q, wdata_d_q, rdata_d_q;
  logic [WdW-1:0]  wdog_q;
  logic [1:0]      ovf_q;

  logic            grant_d;
  logic            timeout;
  logic            acc_done;
  logic            g_rw, g_byte;
  logic [WORD-1:0] g_addr, g_wdata;

  always_comb begin
    g_rw     = grant_q ? rw_d_q    : rw_c_q;
    g_byte   = grant_q ? byte_d_q  : byte_c_q;
    g_addr   = grant_q ? addr_d_q  : addr_c_q;
    g_wdata  = grant_q ? wdata_d_q : wdata_c_q;
    timeout  = (wdog_q == WdW'(TIMEOUT - 1));
    acc_done = (state_q == StAccess) && (memReady_i || timeout);
    // A lone requester always wins; a tie goes against the last grant unless C has priority.
    if (FIXED_PRIO != 0)             grant_d = ~pend_c_q;
    else if (pend_c_q && pend_d_q)   grant_d = ~last_q;
    else                             grant_d = ~pend_c_q;
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q   <= StIdle;
      pend_c_q  <= 1'b0;
      pend_d_q  <= 1'b0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
      rw_c_q    <= 1'b0;
      byte_c_q  <= 1'b0;
      addr_c_q  <= '0;
      wdata_c_q <= '0;
      rdata_c_q <= '0;
      rw_d_q    <= 1'b0;
      byte_d_q  <= 1'b0;
      addr_d_q  <= '0;
      wdata_d_q <= '0;
      rdata_d_q <= '0;
      wdog_q    <= '0;
      ovf_q     <= '0;
    end else begin
      ovf_q <= {dEn_i & pend_d_q, cEn_i & pend_c_q};
      if (cEn_i && !pend_c_q) begin
        rw_c_q    <= cRW_i;
        byte_c_q  <= cByte_i;
        addr_c_q  <= cAddr_i;
        wdata_c_q <= cWData_i;
        pend_c_q  <= 1'b1;
      end
      if (dEn_i && !pend_d_q) begin
        rw_d_q    <= dRW_i;
        byte_d_q  <= dByte_i;
        addr_d_q  <= dAddr_i;
        wdata_d_q <= dWData_i;
        pend_d_q  <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (pend_c_q || pend_d_q) begin
            grant_q <= grant_d;
            last_q  <= grant_d;
            wdog_q  <= '0;
            err_q   <= 1'b0;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (acc_done) begin
            // Ready on the final watchdog cycle still counts as success.
            err_q   <= ~memReady_i;
            state_q <= StDone;
            if (grant_q) pend_d_q <= 1'b0;
            else         pend_c_q <= 1'b0;
            if (memReady_i && !g_rw) begin
              if (grant_q) rdata_d_q <= memRData_i;
              else         rdata_c_q <= memRData_i;
            end
          end else begin
            wdog_q <= wdog_q + WdW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    memEn_o    = (state_q == StAccess);
    memRW_o    = memEn_o & g_rw;
    memByte_o  = memEn_o & g_byte;
    memAddr_o  = memEn_o ? g_addr  : '0;
    memWData_o = memEn_o ? g_wdata : '0;
    cBusy_o    = pend_c_q;
    dBusy_o    = pend_d_q;
    cWr_o      = (state_q == StDone) & ~grant_q;
    dWr_o      = (state_q == StDone) &  grant_q;
    cErr_o     = cWr_o & err_q;
    dErr_o     = dWr_o & err_q;
    cRData_o   = rdata_c_q;
    dRData_o   = rdata_d_q;
    ovf_o      = ovf_q;
  end

endmodule

// File: tb/tb_xm_mem_arbiter.sv
// Bench for xm_mem_arbiter: directed vector table, hand corner sequences and a randomized
// run checked every cycle against a timestamp-based reference model.
module tb_xm_mem_arbiter;
  localparam int unsigned W  = 16;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst = 1'b1;
  logic c_en = 0, c_rw = 0, c_byte = 0, d_en = 0, d_rw = 0, d_byte = 0;
  logic [W-1:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
  logic c_busy, c_wr, c_err, d_busy, d_wr, d_err;
  logic [W-1:0] c_rdata, d_rdata;
  logic [1:0] ovf;
  logic mem_en, mem_rw, mem_byte;
  logic [W-1:0] mem_addr, mem_wdata;
  logic [W-1:0] mem_rdata = '0;
  logic mem_ready = 1'b0;

  logic f_c_en = 0, f_d_en = 0;
  logic f_c_busy, f_c_wr, f_c_err, f_d_busy, f_d_wr, f_d_err;
  logic [W-1:0] f_c_rdata, f_d_rdata, f_mem_addr, f_mem_wdata;
  logic [1:0] f_ovf;
  logic f_mem_en, f_mem_rw, f_mem_byte;

  xm_mem_arbiter #(.WORD(W), .TIMEOUT(TO), .FIXED_PRIO(0)) dut (
    .clk_i(clk), .arst_i(arst),
    .cEn_i(c_en), .cRW_i(c_rw), .cByte_i(c_byte), .cAddr_i(c_addr), .cWData_i(c_wdata),
    .cBusy_o(c_busy), .cWr_o(c_wr), .cErr_o(c_err), .cRData_o(c_rdata),
    .dEn_i(d_en), .dRW_i(d_rw), .dByte_i(d_byte), .dAddr_i(d_addr), .dWData_i(d_wdata),
    .dBusy_o(d_busy), .dWr_o(d_wr), .dErr_o(d_err), .dRData_o(d_rdata),
    .ovf_o(ovf), .memEn_o(mem_en), .memRW_o(mem_rw), .memByte_o(mem_byte),
    .memAddr_o(mem_addr), .memWData_o(mem_wdata), .memRData_i(mem_rdata),
    .memReady_i(mem_ready)
  );

  // Fixed-priority instance on zero-wait memory.
  xm_mem_arbiter #(.WORD(W), .TIMEOUT(TO), .FIXED_PRIO(1)) dut_fp (
    .clk_i(clk), .arst_i(arst),
    .cEn_i(f_c_en), .cRW_i(1'b0), .cByte_i(1'b0), .cAddr_i('0), .cWData_i('0),
    .cBusy_o(f_c_busy), .cWr_o(f_c_wr), .cErr_o(f_c_err), .cRData_o(f_c_rdata),
    .dEn_i(f_d_en), .dRW_i(1'b0), .dByte_i(1'b0), .dAddr_i('0), .dWData_i('0),
    .dBusy_o(f_d_busy), .dWr_o(f_d_wr), .dErr_o(f_d_err), .dRData_o(f_d_rdata),
    .ovf_o(f_ovf), .memEn_o(f_mem_en), .memRW_o(f_mem_rw), .memByte_o(f_mem_byte),
    .memAddr_o(f_mem_addr), .memWData_o(f_mem_wdata), .memRData_i('0),
    .memReady_i(f_mem_en)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] obs();
    return {53'd0, mem_en, mem_rw, mem_byte, mem_addr, mem_wdata, c_busy, d_busy,
            c_wr, d_wr, c_err, d_err, ovf, c_rdata, d_rdata};
  endfunction

  function automatic logic [127:0] ex(bit me, bit rw, bit by, logic [W-1:0] a, logic [W-1:0] wd,
                                      bit cb, bit db, bit cw, bit dw, bit ce, bit de,
                                      logic [1:0] ov, logic [W-1:0] cr, logic [W-1:0] dr);
    return {53'd0, me, rw, by, a, wd, cb, db, cw, dw, ce, de, ov, cr, dr};
  endfunction

  // Reference model: per-port request slots plus timestamps of the current access.
  typedef struct packed {logic rw; logic byt; logic [W-1:0] addr; logic [W-1:0] wdata;} req_t;
  typedef struct packed {
    logic rst; logic [1:0] en; req_t c; req_t d; logic ready; logic [W-1:0] rdata;
  } pin_t;

  pin_t p;
  logic [1:0] m_pend, m_ovf;
  req_t m_fld [2];
  logic [W-1:0] m_rdata [2];
  logic m_last, m_err;
  int m_owner, m_start, m_done;

  task automatic model_step(int c);
    logic [1:0] old, clr;
    int w;
    if (p.rst) begin
      m_pend = '0; m_ovf = '0; m_last = 1'b1; m_err = 1'b0;
      m_rdata[0] = '0; m_rdata[1] = '0; m_fld[0] = '0; m_fld[1] = '0;
      m_owner = -1; m_start = 0; m_done = -1;
      return;
    end
    old = m_pend;
    clr = '0;
    if (m_owner >= 0 && m_done < 0 && c - 1 >= m_start &&
        (p.ready || (c - 1 - m_start) == int'(TO) - 1)) begin
      m_done = c;
      m_err = !p.ready;
      clr[m_owner] = 1'b1;
      if (p.ready && !m_fld[m_owner].rw) m_rdata[m_owner] = p.rdata;
    end
    for (int x = 0; x < 2; x++) begin
      m_ovf[x] = p.en[x] & old[x];
      if (p.en[x] && !old[x]) m_fld[x] = (x == 0) ? p.c : p.d;
      m_pend[x] = (old[x] & !clr[x]) | (p.en[x] & !old[x]);
    end
    if ((m_owner < 0 || (m_done >= 0 && c > m_done)) && m_pend != 2'b00) begin
      w = (m_pend == 2'b11) ? (m_last ? 0 : 1) : (m_pend[0] ? 0 : 1);
      m_owner = w; m_start = c + 1; m_done = -1; m_last = (w == 1);
    end
  endtask

  function automatic logic [127:0] expv(int c);
    logic acc;
    req_t f;
    logic [1:0] wr;
    acc = (m_owner >= 0) && (m_done < 0) && (c >= m_start);
    f = '0;
    if (acc) f = m_fld[m_owner];
    wr = '0;
    if (m_owner >= 0 && m_done == c) wr[m_owner] = 1'b1;
    return ex(acc, f.rw, f.byt, f.addr, f.wdata, m_pend[0], m_pend[1], wr[0], wr[1],
              wr[0] & m_err, wr[1] & m_err, m_ovf, m_rdata[0], m_rdata[1]);
  endfunction

  // Memory responder and event counters.
  bit mem_auto = 0, rand_lat = 0;
  int lat_cfg = 0, cur_lat = 0, mem_age = 0;
  int n_cwr, n_dwr, n_ovfc, n_men, n_bad_addr;
  logic last_cerr;
  logic [W-1:0] want_addr;

  task automatic tick();
    p.rst = arst; p.en = {d_en, c_en};
    p.c = {c_rw, c_byte, c_addr, c_wdata};
    p.d = {d_rw, d_byte, d_addr, d_wdata};
    p.ready = mem_ready; p.rdata = mem_rdata;
    @(posedge clk);
    #1;
    cyc++;
    model_step(cyc);
    check($sformatf("model@%0d", cyc), obs(), expv(cyc));
    n_cwr += int'(c_wr); n_dwr += int'(d_wr); n_ovfc += int'(ovf[0]); n_men += int'(mem_en);
    if (mem_en && mem_addr != want_addr) n_bad_addr++;
    if (c_wr) last_cerr = c_err;
    if (mem_auto) begin
      if (!mem_en) begin
        mem_age = 0;
        mem_ready = ($urandom_range(0, 3) == 0);
      end else begin
        if (mem_age == 0) cur_lat = rand_lat ? int'($urandom_range(0, 9)) : lat_cfg;
        mem_ready = (mem_age == cur_lat);
        mem_age++;
      end
      mem_rdata = W'($urandom);
    end
  endtask

  task automatic clr_cnt();
    n_cwr = 0; n_dwr = 0; n_ovfc = 0; n_men = 0; n_bad_addr = 0; last_cerr = 1'bx;
  endtask

  task automatic req(bit c, bit d, bit rw, logic [W-1:0] a);
    c_en = c; d_en = d; c_rw = rw; d_rw = rw; c_byte = 0; d_byte = 0;
    c_addr = a; d_addr = a; c_wdata = ~a; d_wdata = ~a;
    tick();
    c_en = 0; d_en = 0;
  endtask

  task automatic do_reset();
    arst = 1; tick(); arst = 0;
  endtask

  task automatic serve_two(output int first, output int second);
    int got;
    got = 0; first = -1; second = -1;
    for (int k = 0; k < 40 && got < 2; k++) begin
      tick();
      if (c_wr || d_wr) begin
        if (got == 0) first = d_wr ? 1 : 0;
        else second = d_wr ? 1 : 0;
        got++;
      end
    end
  endtask

  task automatic wait_wr(int bound);
    for (int k = 0; k < bound && n_cwr == 0; k++) tick();
  endtask

  typedef struct {
    logic c_en, d_en, rw, byt;
    logic [W-1:0] addr, wdata;
    logic ready;
    logic [W-1:0] rdata;
    logic [127:0] exp;
  } vec_t;
  vec_t vt [11];

  initial begin
    int f0, s0;
    int fc, fd;
    logic [W-1:0] keep;

    vt[0]  = '{1, 0, 0, 0, 16'h0040, 16'h0000, 0, 16'h0000, ex(0,0,0,0,0, 0,0,0,0,0,0, 0, 0, 0)};
    vt[1]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, ex(0,0,0,0,0, 1,0,0,0,0,0, 0, 0, 0)};
    vt[2]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF,
               ex(1,0,0,16'h0040,0, 1,0,0,0,0,0, 0, 0, 0)};
    vt[3]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,
               ex(0,0,0,0,0, 0,0,1,0,0,0, 0, 16'hBEEF, 0)};
    vt[4]  = '{0, 1, 1, 1, 16'h0101, 16'h00AA, 0, 16'h0000,
               ex(0,0,0,0,0, 0,0,0,0,0,0, 0, 16'hBEEF, 0)};
    vt[5]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,
               ex(0,0,0,0,0, 0,1,0,0,0,0, 0, 16'hBEEF, 0)};
    for (int i = 6; i < 10; i++)
      vt[i] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,
                ex(1,1,1,16'h0101,16'h00AA, 0,1,0,0,0,0, 0, 16'hBEEF, 0)};
    vt[9].ready = 1; vt[9].rdata = 16'h1234;
    vt[10] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,
               ex(0,0,0,0,0, 0,0,0,1,0,0, 0, 16'hBEEF, 0)};

    // Directed table: zero-wait C read, then D byte write with three wait cycles.
    clr_cnt(); want_addr = '0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      check($sformatf("vec[%0d]", i), obs(), vt[i].exp);
      c_en = vt[i].c_en; d_en = vt[i].d_en; c_rw = vt[i].rw; d_rw = vt[i].rw;
      c_byte = vt[i].byt; d_byte = vt[i].byt; c_addr = vt[i].addr; d_addr = vt[i].addr;
      c_wdata = vt[i].wdata; d_wdata = vt[i].wdata;
      mem_ready = vt[i].ready; mem_rdata = vt[i].rdata;
      tick();
    end
    c_en = 0; d_en = 0;

    // Round-robin tie-break from reset, twice.
    mem_auto = 1; lat_cfg = 0;
    do_reset();
    req(1, 1, 0, 16'h0010);
    serve_two(f0, s0);
    check("rr1_first", 128'(f0), 128'(0));
    check("rr1_second", 128'(s0), 128'(1));
    tick();
    req(1, 1, 0, 16'h0020);
    serve_two(f0, s0);
    check("rr2_first", 128'(f0), 128'(0));
    check("rr2_second", 128'(s0), 128'(1));
    tick();

    // Watchdog abort, recovery, and ready on the final allowed cycle.
    keep = c_rdata;
    lat_cfg = 100; clr_cnt(); want_addr = 16'h0200;
    req(1, 0, 0, 16'h0200);
    wait_wr(40);
    check("tmo_men_cycles", 128'(n_men), 128'(TO));
    check("tmo_err", 128'(last_cerr), 128'(1));
    check("tmo_rdata_hold", 128'(c_rdata), 128'(keep));
    tick();
    lat_cfg = 0; clr_cnt(); want_addr = 16'h0204;
    req(1, 0, 0, 16'h0204);
    wait_wr(40);
    check("after_tmo_wr", 128'(n_cwr), 128'(1));
    check("after_tmo_err", 128'(last_cerr), 128'(0));
    tick();
    lat_cfg = int'(TO) - 1; clr_cnt(); want_addr = 16'h0208;
    req(1, 0, 0, 16'h0208);
    wait_wr(40);
    check("lastcyc_men", 128'(n_men), 128'(TO));
    check("lastcyc_err", 128'(last_cerr), 128'(0));
    tick();

    // Second request while busy is dropped.
    lat_cfg = 3; clr_cnt(); want_addr = 16'h0300;
    req(1, 0, 0, 16'h0300);
    req(1, 0, 0, 16'h0BAD);
    for (int k = 0; k < 15; k++) tick();
    check("ovf_pulses", 128'(n_ovfc), 128'(1));
    check("ovf_one_wr", 128'(n_cwr), 128'(1));
    check("ovf_orig_addr", 128'(n_bad_addr), 128'(0));
    check("ovf_accesses", 128'(n_men), 128'(4));

    // Reset in the middle of an access with ready high.
    lat_cfg = 100; want_addr = 16'h0400;
    req(1, 0, 0, 16'h0400);
    tick(); tick();
    check("pre_rst_active", 128'(mem_en), 128'(1));
    mem_auto = 0; mem_ready = 1; arst = 1;
    tick();
    arst = 0; mem_ready = 0;
    check("rst_mid_outputs", obs(), 128'(0));
    mem_auto = 1; clr_cnt();
    for (int k = 0; k < 5; k++) tick();
    check("rst_mid_no_wr", 128'(n_cwr), 128'(0));

    // Fixed priority: C re-requesting in every DONE cycle starves D.
    fc = 0; fd = 0;
    f_c_en = 1; f_d_en = 1;
    tick();
    f_c_en = 0; f_d_en = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      fc += int'(f_c_wr); fd += int'(f_d_wr);
      f_c_en = f_c_wr;
    end
    check("fp_d_starved", 128'(fd), 128'(0));
    check("fp_c_served", 128'(fc >= 8), 128'(1));
    check("fp_d_busy", 128'(f_d_busy), 128'(1));
    f_c_en = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      fd += int'(f_d_wr);
    end
    check("fp_d_after", 128'(fd), 128'(1));

    // Randomized traffic with occasional resets against the model.
    rand_lat = 1;
    for (int k = 0; k < 2000; k++) begin
      c_en = ($urandom_range(0, 3) == 0); d_en = ($urandom_range(0, 3) == 0);
      c_rw = 1'($urandom); d_rw = 1'($urandom); c_byte = 1'($urandom); d_byte = 1'($urandom);
      c_addr = W'($urandom); d_addr = W'($urandom);
      c_wdata = W'($urandom); d_wdata = W'($urandom);
      arst = ($urandom_range(0, 299) == 0);
      tick();
    end
    arst = 0; c_en = 0; d_en = 0;
    for (int k = 0; k < 30; k++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no end of test, required finish before time limit");
    $fatal(1, "time limit");
  end

endmodule
